// File: rtl/privtrap_if.sv
// privtrap_if: M-stage bundle between the privileged-instruction decoder,
// the CSR file and the trap sequencer.
//   master: decoder/CSR side (drives faults, returns, CSR views; reads trap results)
//   slave : privtrap (reads the above, drives trap/return/WFI/privilege outputs)
interface privtrap_if;
  logic        StallM;
  logic        IllegalInstrFaultM, EcallFaultM, BreakpointFaultM;
  logic        mretM, sretM, wfiM;
  logic        InstrMisalignedFaultM, InstrAccessFaultM;
  logic        LoadMisalignedFaultM, LoadAccessFaultM;
  logic        StoreAmoMisalignedFaultM, StoreAmoAccessFaultM;
  logic [11:0] MIP_REGW, MIE_REGW;
  logic [15:0] MEDELEG_REGW;
  logic [11:0] MIDELEG_REGW;
  logic        STATUS_MIE, STATUS_SIE;
  logic [1:0]  STATUS_MPP;
  logic        STATUS_SPP;
  logic        TrapM, InterruptM, DelegateM, RetM, WFIStallM;
  logic [3:0]  CauseM;
  logic [1:0]  PrivilegeModeW;

  modport master (
    output StallM, IllegalInstrFaultM, EcallFaultM, BreakpointFaultM,
           mretM, sretM, wfiM, InstrMisalignedFaultM, InstrAccessFaultM,
           LoadMisalignedFaultM, LoadAccessFaultM, StoreAmoMisalignedFaultM,
           StoreAmoAccessFaultM, MIP_REGW, MIE_REGW, MEDELEG_REGW, MIDELEG_REGW,
           STATUS_MIE, STATUS_SIE, STATUS_MPP, STATUS_SPP,
    input  TrapM, InterruptM, CauseM, DelegateM, RetM, WFIStallM, PrivilegeModeW
  );

  modport slave (
    input  StallM, IllegalInstrFaultM, EcallFaultM, BreakpointFaultM,
           mretM, sretM, wfiM, InstrMisalignedFaultM, InstrAccessFaultM,
           LoadMisalignedFaultM, LoadAccessFaultM, StoreAmoMisalignedFaultM,
           StoreAmoAccessFaultM, MIP_REGW, MIE_REGW, MEDELEG_REGW, MIDELEG_REGW,
           STATUS_MIE, STATUS_SIE, STATUS_MPP, STATUS_SPP,
    output TrapM, InterruptM, CauseM, DelegateM, RetM, WFIStallM, PrivilegeModeW
  );
endinterface

// File: rtl/privtrap.sv
// privtrap: M-stage trap arbitration and privilege-mode sequencer.
//   clk   : core clock
//   reset : asynchronous, active-low
//   bus   : privtrap_if.slave -- faults/returns/wfi and CSR views in;
//           TrapM, InterruptM, CauseM, DelegateM, RetM (combinational),
//           WFIStallM, PrivilegeModeW (registered) out.
module privtrap #(
  parameter bit S_SUPPORTED = 1'b1,
  parameter bit U_SUPPORTED = 1'b1
) (
  input logic       clk,
  input logic       reset,
  privtrap_if.slave bus
);
  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_WAKE} wfi_state_t;

  logic [11:0] int_pend_q, live_pend, deleg_int, int_en, valid_int;
  logic [1:0]  priv_q, mret_mode;
  logic        s_int_ok, m_int_ok, int_any, exc_any, trap, deleg, wfi_stall_q;
  logic [3:0]  int_cause, exc_cause, cause;
  logic [15:0] mideleg_ext;
  wfi_state_t  wfi_state;

  assign live_pend = bus.MIP_REGW & bus.MIE_REGW;

  // Registered pending set; captured even while stalled.
  always_ff @(posedge clk or negedge reset)
    if (!reset) int_pend_q <= '0;
    else        int_pend_q <= live_pend;

  // Delegated interrupts are only taken below M; non-delegated ones are
  // always taken below M and in M only with MIE.
  assign deleg_int = bus.MIDELEG_REGW & {12{S_SUPPORTED}};
  assign s_int_ok  = (priv_q == U_MODE) | ((priv_q == S_MODE) & bus.STATUS_SIE);
  assign m_int_ok  = (priv_q != M_MODE) | bus.STATUS_MIE;
  assign int_en    = (deleg_int & {12{s_int_ok}}) | (~deleg_int & {12{m_int_ok}});
  assign valid_int = int_pend_q & int_en;
  assign int_any   = |valid_int;

  always_comb begin
    int_cause = 4'd0;
    if      (valid_int[11]) int_cause = 4'd11;
    else if (valid_int[3])  int_cause = 4'd3;
    else if (valid_int[7])  int_cause = 4'd7;
    else if (valid_int[9])  int_cause = 4'd9;
    else if (valid_int[1])  int_cause = 4'd1;
    else if (valid_int[5])  int_cause = 4'd5;
  end

  always_comb begin
    exc_any   = 1'b1;
    exc_cause = 4'd0;
    if      (bus.InstrAccessFaultM)        exc_cause = 4'd1;
    else if (bus.IllegalInstrFaultM)       exc_cause = 4'd2;
    else if (bus.InstrMisalignedFaultM)    exc_cause = 4'd0;
    else if (bus.EcallFaultM)              exc_cause = 4'd8 + {2'b00, priv_q};
    else if (bus.BreakpointFaultM)         exc_cause = 4'd3;
    else if (bus.StoreAmoMisalignedFaultM) exc_cause = 4'd6;
    else if (bus.LoadMisalignedFaultM)     exc_cause = 4'd4;
    else if (bus.StoreAmoAccessFaultM)     exc_cause = 4'd7;
    else if (bus.LoadAccessFaultM)         exc_cause = 4'd5;
    else                                   exc_any   = 1'b0;
  end

  assign cause       = int_any ? int_cause : exc_cause;
  assign trap        = int_any | exc_any;
  assign mideleg_ext = {4'b0000, bus.MIDELEG_REGW};
  assign deleg       = S_SUPPORTED & (priv_q != M_MODE) &
                       (int_any ? mideleg_ext[cause] : bus.MEDELEG_REGW[cause]);

  // mret target: no U means always M; S without S support collapses to U.
  always_comb begin
    mret_mode = bus.STATUS_MPP;
    if (!U_SUPPORTED)                                     mret_mode = M_MODE;
    else if ((bus.STATUS_MPP == S_MODE) && !S_SUPPORTED)  mret_mode = U_MODE;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) priv_q <= M_MODE;
    else if (!bus.StallM) begin
      if      (trap)      priv_q <= deleg ? S_MODE : M_MODE;
      else if (bus.mretM) priv_q <= mret_mode;
      else if (bus.sretM) priv_q <= {1'b0, bus.STATUS_SPP};
    end

  // WFI sequencer. Wake uses the live pending set (global enables ignored)
  // and is not gated by StallM so a stalled WAIT can still release.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wfi_state   <= ST_RUN;
      wfi_stall_q <= 1'b0;
    end else begin
      case (wfi_state)
        ST_RUN:
          if (bus.wfiM && !trap && !bus.StallM && (live_pend == '0)) begin
            wfi_state   <= ST_WAIT;
            wfi_stall_q <= 1'b1;
          end
        ST_WAIT:
          if ((live_pend != '0) || trap) begin
            wfi_state   <= ST_WAKE;
            wfi_stall_q <= 1'b0;
          end
        default: begin
          wfi_state   <= ST_RUN;
          wfi_stall_q <= 1'b0;
        end
      endcase
    end

  assign bus.TrapM          = trap;
  assign bus.InterruptM     = int_any;
  assign bus.CauseM         = cause;
  assign bus.DelegateM      = deleg;
  assign bus.RetM           = (bus.mretM | bus.sretM) & ~trap;
  assign bus.WFIStallM      = wfi_stall_q;
  assign bus.PrivilegeModeW = priv_q;
endmodule

// File: tb/tb_privtrap.sv
module tb_privtrap;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  privtrap_if bus();
  privtrap dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    string      name;
    logic       trap, intr, deleg, ret, wfi;
    logic [3:0] cause;
    logic [1:0] priv;
  } exp_t;

  exp_t q[$];
  int   n_run = 0;
  int   n_fail = 0;

  task automatic clr();
    bus.StallM = 0; bus.IllegalInstrFaultM = 0; bus.EcallFaultM = 0;
    bus.BreakpointFaultM = 0; bus.mretM = 0; bus.sretM = 0; bus.wfiM = 0;
    bus.InstrMisalignedFaultM = 0; bus.InstrAccessFaultM = 0;
    bus.LoadMisalignedFaultM = 0; bus.LoadAccessFaultM = 0;
    bus.StoreAmoMisalignedFaultM = 0; bus.StoreAmoAccessFaultM = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic exp(input string name, input logic trap, input logic intr,
                     input logic [3:0] cause, input logic deleg, input logic ret,
                     input logic wfi, input logic [1:0] priv);
    exp_t e;
    e.name = name; e.trap = trap; e.intr = intr; e.cause = cause;
    e.deleg = deleg; e.ret = ret; e.wfi = wfi; e.priv = priv;
    q.push_back(e);
  endtask

  // Monitor: compares the entry queued for this cycle, mid-cycle.
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_run++;
      if (bus.TrapM !== e.trap || bus.InterruptM !== e.intr ||
          bus.DelegateM !== e.deleg || bus.RetM !== e.ret ||
          bus.WFIStallM !== e.wfi || bus.PrivilegeModeW !== e.priv ||
          (e.trap && bus.CauseM !== e.cause)) begin
        n_fail++;
        $display("FAIL %s: got trap=%b int=%b cause=%0d deleg=%b ret=%b wfi=%b priv=%b, want trap=%b int=%b cause=%0d deleg=%b ret=%b wfi=%b priv=%b",
                 e.name, bus.TrapM, bus.InterruptM, bus.CauseM, bus.DelegateM,
                 bus.RetM, bus.WFIStallM, bus.PrivilegeModeW, e.trap, e.intr,
                 e.cause, e.deleg, e.ret, e.wfi, e.priv);
      end
    end
  end

  initial begin
    clr();
    bus.MIP_REGW = 0; bus.MIE_REGW = 0; bus.MEDELEG_REGW = 0; bus.MIDELEG_REGW = 0;
    bus.STATUS_MIE = 0; bus.STATUS_SIE = 0; bus.STATUS_MPP = 0; bus.STATUS_SPP = 0;
    repeat (3) step();
    reset = 1'b1;

    step(); exp("reset", 0, 0, 0, 0, 0, 0, 2'b11);
    step(); bus.EcallFaultM = 1; exp("ecall_m", 1, 0, 11, 0, 0, 0, 2'b11);
    step(); clr(); exp("ecall_m_priv", 0, 0, 0, 0, 0, 0, 2'b11);

    // M -> U via mret
    step(); bus.mretM = 1; bus.STATUS_MPP = 2'b00; exp("mret_u", 0, 0, 0, 0, 1, 0, 2'b11);
    step(); clr(); exp("mret_u_priv", 0, 0, 0, 0, 0, 0, 2'b00);

    // delegated ecall from U
    step(); bus.MEDELEG_REGW = 16'h0100; bus.EcallFaultM = 1;
    exp("ecall_u_deleg", 1, 0, 8, 1, 0, 0, 2'b00);
    step(); clr(); exp("deleg_priv", 0, 0, 0, 0, 0, 0, 2'b01);

    // stalled illegal in S: trap visible, privilege holds until release
    step(); bus.StallM = 1; bus.IllegalInstrFaultM = 1; exp("stall_trap", 1, 0, 2, 0, 0, 0, 2'b01);
    step(); exp("stall_hold", 1, 0, 2, 0, 0, 0, 2'b01);
    step(); bus.StallM = 0; exp("stall_release", 1, 0, 2, 0, 0, 0, 2'b01);
    step(); clr(); exp("stall_priv", 0, 0, 0, 0, 0, 0, 2'b11);

    // exception priority in M
    step(); bus.IllegalInstrFaultM = 1; bus.LoadAccessFaultM = 1; bus.InstrMisalignedFaultM = 1;
    exp("prio_ill", 1, 0, 2, 0, 0, 0, 2'b11);
    step(); clr(); bus.InstrAccessFaultM = 1; bus.IllegalInstrFaultM = 1;
    exp("prio_iacc", 1, 0, 1, 0, 0, 0, 2'b11);
    step(); clr(); bus.EcallFaultM = 1; bus.BreakpointFaultM = 1;
    exp("prio_ecall", 1, 0, 11, 0, 0, 0, 2'b11);
    step(); clr(); bus.BreakpointFaultM = 1; bus.StoreAmoMisalignedFaultM = 1;
    exp("prio_bkpt", 1, 0, 3, 0, 0, 0, 2'b11);
    step(); clr(); bus.StoreAmoMisalignedFaultM = 1; bus.LoadMisalignedFaultM = 1;
    exp("prio_samis", 1, 0, 6, 0, 0, 0, 2'b11);
    step(); clr(); bus.LoadMisalignedFaultM = 1; bus.StoreAmoAccessFaultM = 1;
    exp("prio_lmis", 1, 0, 4, 0, 0, 0, 2'b11);
    step(); clr(); bus.StoreAmoAccessFaultM = 1; bus.LoadAccessFaultM = 1;
    exp("prio_saacc", 1, 0, 7, 0, 0, 0, 2'b11);

    // mret colliding with a load fault: trap wins
    step(); clr(); bus.mretM = 1; bus.STATUS_MPP = 2'b00; bus.LoadAccessFaultM = 1;
    exp("mret_vs_lacc", 1, 0, 5, 0, 0, 0, 2'b11);
    step(); clr(); exp("mret_vs_lacc_priv", 0, 0, 0, 0, 0, 0, 2'b11);

    // M -> S via mret, then interrupt 11 with one-cycle capture latency
    step(); bus.mretM = 1; bus.STATUS_MPP = 2'b01; exp("mret_s", 0, 0, 0, 0, 1, 0, 2'b11);
    step(); clr(); bus.MIP_REGW = 12'h880; bus.MIE_REGW = 12'h880;
    exp("int_latency", 0, 0, 0, 0, 0, 0, 2'b01);
    step(); exp("int_s", 1, 1, 11, 0, 0, 0, 2'b01);
    step(); exp("int_m_masked", 0, 0, 0, 0, 0, 0, 2'b11);
    step(); bus.MIP_REGW = 0; bus.MIE_REGW = 0;
    step();

    // interrupt priority, and interrupt beats exception
    step(); bus.STATUS_MIE = 1; bus.MIP_REGW = 12'h2A2; bus.MIE_REGW = 12'h2A2;
    step(); bus.IllegalInstrFaultM = 1; exp("int_prio", 1, 1, 7, 0, 0, 0, 2'b11);
    step(); clr(); bus.STATUS_MIE = 0; bus.MIP_REGW = 0; bus.MIE_REGW = 0;
    step();

    // trap alongside wfi: no WAIT
    step(); bus.wfiM = 1; bus.BreakpointFaultM = 1; exp("wfi_trap", 1, 0, 3, 0, 0, 0, 2'b11);
    step(); clr(); exp("wfi_trap_run", 0, 0, 0, 0, 0, 0, 2'b11);

    // WFI stall for 10 cycles, wake on masked-but-enabled interrupt
    step(); bus.wfiM = 1; exp("wfi_issue", 0, 0, 0, 0, 0, 0, 2'b11);
    step(); clr();
    for (int i = 0; i < 10; i++) begin
      exp("wfi_stall", 0, 0, 0, 0, 0, 1, 2'b11);
      step();
    end
    bus.MIP_REGW = 12'h080; bus.MIE_REGW = 12'h080;
    exp("wfi_pend", 0, 0, 0, 0, 0, 1, 2'b11);
    step(); exp("wfi_wake", 0, 0, 0, 0, 0, 0, 2'b11);
    step(); bus.MIP_REGW = 0; bus.MIE_REGW = 0; exp("wfi_run", 0, 0, 0, 0, 0, 0, 2'b11);

    // reset in WAIT from U mode
    step(); bus.mretM = 1; bus.STATUS_MPP = 2'b00; exp("mret_u2", 0, 0, 0, 0, 1, 0, 2'b11);
    step(); clr(); bus.wfiM = 1; exp("wfi_u_issue", 0, 0, 0, 0, 0, 0, 2'b00);
    step(); clr(); exp("wfi_u_stall", 0, 0, 0, 0, 0, 1, 2'b00);
    step(); reset = 1'b0; exp("reset_mid_wait", 0, 0, 0, 0, 0, 0, 2'b11);
    step(); reset = 1'b1; exp("reset_release", 0, 0, 0, 0, 0, 0, 2'b11);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_run++; n_fail++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    #2;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
